// File: rtl/rst_release_seq.sv
// Reset-release sequencer: holds ready low for a programmable number of cycles
// after reset or start, then raises ready with a one-cycle done_pulse.
module rst_release_seq #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DLY = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             dly_load,
  input  logic [CNT_W-1:0] dly_val,
  output logic             ready,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] DLY_RST = CNT_W'(DEFAULT_DLY);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO    = '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] dly, dly_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ready_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             load_ok;

  // Reset parks the FSM in COUNT so the power-on delay runs straight after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COUNT;
      cnt        <= ZERO;
      ready      <= 1'b0;
      busy       <= 1'b1;
      done_pulse <= 1'b0;
      dly        <= DLY_RST;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ready      <= ready_nxt;
      busy       <= busy_nxt;
      done_pulse <= done_nxt;
      dly        <= dly_nxt;
    end
  end

  // The delay register is frozen while counting; a zero load is clamped to one.
  assign load_ok = dly_load && (state != COUNT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = ready;
    done_nxt  = 1'b0;
    dly_nxt   = dly;

    if (load_ok) begin
      dly_nxt = (dly_val == ZERO) ? ONE : dly_val;
    end

    // Priority inside each state: abort, then start, then normal progress.
    case (state)
      IDLE: begin
        if (!abort && start) begin
          state_nxt = COUNT;
          cnt_nxt   = ZERO;
          ready_nxt = 1'b0;
        end
      end
      COUNT: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = ZERO;
          ready_nxt = 1'b0;
        end else if (start) begin
          cnt_nxt = ZERO;
        end else if (cnt == dly - ONE) begin
          state_nxt = DONE;
          cnt_nxt   = ZERO;
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = ZERO;
          ready_nxt = 1'b0;
        end else if (start) begin
          state_nxt = COUNT;
          cnt_nxt   = ZERO;
          ready_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = ZERO;
        ready_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt == COUNT);
  end

endmodule

// File: tb/tb_rst_release_seq.sv
// Randomised and directed bench for rst_release_seq, checked against a model that
// tracks release time as "edges elapsed since the count started".
module tb_rst_release_seq;

  localparam int CNT_W       = 8;
  localparam int DEFAULT_DLY = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             dly_load = 1'b0;
  logic [CNT_W-1:0] dly_val = '0;
  logic             ready;
  logic             busy;
  logic             done_pulse;
  logic [CNT_W-1:0] cnt;

  int checks_done = 0;
  int fail_count  = 0;

  // Reference model state.
  int  edge_num    = 0;
  int  origin      = 0;
  int  dreg        = DEFAULT_DLY;
  bit  m_counting  = 1'b1;
  bit  m_ready     = 1'b0;
  bit  m_pulse     = 1'b0;

  rst_release_seq #(
    .CNT_W      (CNT_W),
    .DEFAULT_DLY(DEFAULT_DLY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .dly_load  (dly_load),
    .dly_val   (dly_val),
    .ready     (ready),
    .busy      (busy),
    .done_pulse(done_pulse),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks_done++;
    if (observed != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d (edge %0d)", tag, observed, expected, edge_num);
    end
  endtask

  // Release happens once D edges have elapsed since the edge that began the count.
  task automatic updateModel(input bit r, input bit s, input bit a, input bit l, input int v);
    bit was_counting;
    edge_num++;
    m_pulse = 1'b0;
    if (r) begin
      m_counting = 1'b1;
      m_ready    = 1'b0;
      origin     = edge_num;
      dreg       = DEFAULT_DLY;
      return;
    end
    was_counting = m_counting;
    if (l && !was_counting) dreg = (v == 0) ? 1 : v;
    if (a) begin
      m_counting = 1'b0;
      m_ready    = 1'b0;
    end else if (s) begin
      m_counting = 1'b1;
      m_ready    = 1'b0;
      origin     = edge_num;
    end else if (m_counting && (edge_num - origin) == dreg) begin
      m_counting = 1'b0;
      m_ready    = 1'b1;
      m_pulse    = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit a, input bit l, input int v);
    rst      = r;
    start    = s;
    abort    = a;
    dly_load = l;
    dly_val  = CNT_W'(v);
    @(posedge clk);
    #1;
    updateModel(r, s, a, l, v);
    checkOutput("ready", int'(ready), int'(m_ready));
    checkOutput("busy", int'(busy), int'(m_counting));
    checkOutput("done_pulse", int'(done_pulse), int'(m_pulse));
    checkOutput("cnt", int'(cnt), m_counting ? (edge_num - origin) : 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    bit seen_pulse;

    // Power-on: three reset edges, then the default delay.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("rst_busy", int'(busy), 1);
    checkOutput("rst_ready", int'(ready), 0);
    idle(9);
    checkOutput("por_ready_e10", int'(ready), 0);
    idle(1);
    checkOutput("por_ready_e11", int'(ready), 1);
    checkOutput("por_pulse_e11", int'(done_pulse), 1);
    idle(1);
    checkOutput("por_pulse_e12", int'(done_pulse), 0);

    // Reload with start from DONE.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 3);
    checkOutput("reload_drop", int'(ready), 0);
    idle(2);
    checkOutput("reload_busy", int'(busy), 1);
    idle(1);
    checkOutput("reload_ready", int'(ready), 1);

    // Retrigger at cnt=5.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 10);
    idle(5);
    checkOutput("retrig_cnt5", int'(cnt), 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("retrig_cnt0", int'(cnt), 0);
    idle(9);
    checkOutput("retrig_ready_early", int'(ready), 0);
    idle(1);
    checkOutput("retrig_ready", int'(ready), 1);

    // Abort beats start.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("prio_cnt", int'(cnt), 0);
    checkOutput("prio_busy", int'(busy), 0);
    seen_pulse = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (done_pulse) seen_pulse = 1'b1;
    end
    checkOutput("prio_no_pulse", int'(seen_pulse), 0);

    // Zero delay clamps to one cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 0);
    idle(1);
    checkOutput("zero_dly_ready", int'(ready), 1);

    // Load during COUNT is ignored for this and the next count.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2);
    idle(3);
    checkOutput("ign_load_early", int'(ready), 0);
    idle(1);
    checkOutput("ign_load_ready", int'(ready), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(4);
    checkOutput("ign_load_next", int'(ready), 0);
    idle(1);
    checkOutput("ign_load_next_rdy", int'(ready), 1);

    // Reset mid-count restores the default delay.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 20);
    idle(7);
    checkOutput("midrst_cnt7", int'(cnt), 7);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
    idle(9);
    checkOutput("midrst_early", int'(ready), 0);
    idle(1);
    checkOutput("midrst_ready", int'(ready), 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
    $finish;
  end

endmodule
